mc_mem_bus_ctrl: RTL and testbench
==================================

Name: mc_mem_bus_ctrl

Overview:
- Memory-access sequencer between the multicycle CPU datapath and a slow word-wide memory bus.
- Accepts the datapath's memory cycle: the address selected by iord, store data, and the wmem strobe or a read strobe.
- Runs a req/ack handshake on the external bus, with timeout and alignment checks.
- Holds the CPU in its current control state via cpu_stall until the data phase completes.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TMO, 16, maximum bus wait cycles before abort (≥2)
- CW, 5, timeout counter width (2^CW > TMO)

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous reset, active-high (despite the name)
- cpu_rd  in  1  read request from the datapath (lw fetch/data read)
- cpu_wr  in  1  write request (wmem)
- cpu_addr  in  AW  byte address
- cpu_wdata  in  DW  store data
- cpu_rdata  out  DW  read data, valid in the DONE cycle and held until the next capture
- cpu_stall  out  1  freeze the CPU control state and PC/IR writes
- bus_req  out  1  bus request
- bus_we  out  1  bus write enable
- bus_addr  out  AW  bus word address (byte address, bits [1:0] forced 0)
- bus_wdata  out  DW  bus write data
- bus_ack  in  1  bus completion, single-cycle pulse
- bus_rdata  in  DW  bus read data, valid with bus_ack
- err_clr  in  1  clears sticky error flags
- err_align  out  1  sticky: misaligned access
- err_tmo  out  1  sticky: bus timeout

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (async, resetn=1):
  - State goes to IDLE.
  - bus_req, bus_we, err_align and err_tmo go to 0.
  - bus_addr, bus_wdata and cpu_rdata go to 0.
  - Timeout counter goes to 0.
  - A reset mid-transaction drops bus_req immediately. Any late bus_ack is ignored while in IDLE.
- Request: req = cpu_rd | cpu_wr. If both are high, write wins.
- cpu_stall = (state==IDLE & req) | (state==BUSY). This is combinational, so the CPU stalls in the same cycle it issues the request.
- IDLE, req=1, cpu_addr[1:0]==0:
  - Latch addr, wdata and we.
  - Assert bus_req and bus_we (registered).
  - Clear the counter and go to BUSY.
- IDLE, req=1, misaligned:
  - No bus cycle. Set err_align and go to DONE.
  - A read returns cpu_rdata = 0. A write is discarded.
- BUSY:
  - bus_req held at 1. Counter increments each cycle.
  - bus_ack=1: capture bus_rdata into cpu_rdata if reading, drop bus_req, go to DONE.
  - Counter reaches TMO-1 without ack: drop bus_req, set err_tmo, cpu_rdata = 0 on a read, go to DONE.
  - ack and the timeout in the same cycle: ack wins and err_tmo is not set.
- DONE:
  - cpu_stall = 0 for exactly one cycle, so the CPU advances.
  - req is ignored in this cycle. Next state is always IDLE.
- Latency:
  - Aligned access, ack k cycles after bus_req rises (k≥1): stall lasts 1+k cycles, and DONE follows the ack edge.
  - Minimum total is 3 cycles from request to IDLE.
- bus_ack outside BUSY is ignored.
- Sticky errors clear on err_clr=1. Setting the flag beats clearing it in the same cycle.
- bus_addr, bus_we and bus_wdata stay stable for the whole time bus_req=1.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'b00, BUSY=2'b01, DONE=2'b10.
  - Bus width constants shared with the CPU datapath.
- One natural sub-module, mc_tmo_counter: clear/enable/terminal-count counter, width CW, terminal value TMO-1.

Test Plan:
- Read at 0x0000_0010, ack 2 cycles after bus_req: bus_addr=0x10, bus_we=0, stall high 3 cycles, cpu_rdata=0xCAFE_F00D in DONE, no errors.
- Write of 0x1234_5678 to 0x0000_0020, immediate ack: bus_we=1, bus_wdata stable while bus_req=1, stall 2 cycles, DONE then IDLE.
- Read at 0x0000_0013: bus_req never rises, err_align=1, cpu_rdata=0, stall 1 cycle. Then err_clr pulse gives err_align=0.
- Read with no ack (TMO=16): bus_req high 16 cycles then drops, err_tmo=1, cpu_rdata=0, next state IDLE. A later stray bus_ack changes nothing.
- Ack arrives in the timeout-terminal cycle: transfer succeeds and err_tmo stays 0. Separately, cpu_rd and cpu_wr both high: bus_we=1.
- resetn pulse during BUSY: bus_req drops asynchronously, state IDLE. A bus_ack in the next cycle gives no DONE and no rdata update.

Source files
------------

// File: rtl/mc_mem_bus_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_mem_bus_ctrl_pkg
// Shared definitions for the multicycle CPU memory-bus sequencer:
//   - state encoding of the access sequencer (IDLE / BUSY / DONE)
//   - bus width constants shared with the CPU datapath
//   - word-alignment helper used on the byte address
// ---------------------------------------------------------------------------
package mc_mem_bus_ctrl_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // A word access is legal only when the two byte-offset bits are zero.
  function automatic logic is_word_aligned(input logic [1:0] byte_off);
    return (byte_off == 2'b00);
  endfunction

endpackage

// File: rtl/mc_mem_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// mc_mem_bus_ctrl_if
// Word-wide memory bus between the sequencer (master) and the memory (slave).
//   bus_req   master->slave  request, held until ack or abort
//   bus_we    master->slave  write enable, stable while bus_req=1
//   bus_addr  master->slave  word address (bits [1:0] are zero)
//   bus_wdata master->slave  write data, stable while bus_req=1
//   bus_ack   slave->master  single-cycle completion pulse
//   bus_rdata slave->master  read data, valid with bus_ack
// ---------------------------------------------------------------------------
interface mc_mem_bus_ctrl_if
  import mc_mem_bus_ctrl_pkg::*;
#(
  parameter int AW = BUS_AW,
  parameter int DW = BUS_DW
) ();

  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/mc_mem_bus_ctrl_tmo.sv
// ---------------------------------------------------------------------------
// mc_tmo_counter
// Bus-wait timeout counter.
//   clock  in   system clock
//   resetn in   asynchronous reset, active-high
//   clr    in   synchronous clear (has priority over en)
//   en     in   count enable
//   tc     out  terminal count: counter value equals TMO-1
// ---------------------------------------------------------------------------
module mc_tmo_counter #(
  parameter int TMO = 16,
  parameter int CW  = 5
) (
  input  logic clock,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CW'(TMO - 1));

endmodule

// File: rtl/mc_mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mc_mem_bus_ctrl
// Memory-access sequencer between the multicycle CPU datapath and a slow
// word-wide bus. One CPU access becomes one req/ack bus cycle; the CPU is
// held via cpu_stall until the access completes (DONE releases it for
// exactly one cycle). Misaligned accesses and bus timeouts are reported
// through sticky error flags.
//   clock, resetn        clock; asynchronous active-high reset
//   cpu_rd, cpu_wr       access request (write wins when both are set)
//   cpu_addr, cpu_wdata  byte address and store data
//   cpu_rdata            read data, updated in the DONE cycle and then held
//   cpu_stall            combinational stall back to the CPU control
//   err_clr              clears sticky errors (a new error wins)
//   err_align, err_tmo   sticky misaligned / timeout flags
//   bus                  master side of the word bus
// ---------------------------------------------------------------------------
module mc_mem_bus_ctrl
  import mc_mem_bus_ctrl_pkg::*;
#(
  parameter int AW  = BUS_AW,
  parameter int DW  = BUS_DW,
  parameter int TMO = 16,
  parameter int CW  = 5
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          err_clr,
  output logic          err_align,
  output logic          err_tmo,
  mc_mem_bus_ctrl_if.master bus
);

  state_t state;
  logic   req;
  logic   tmo_tc;

  assign req = cpu_rd | cpu_wr;

  // Stall in the very cycle the request appears, so the CPU control state
  // never advances past an access that has not completed.
  assign cpu_stall = ((state == ST_IDLE) && req) || (state == ST_BUSY);

  // Counter is held cleared in IDLE, so every bus cycle starts from zero.
  mc_tmo_counter #(
    .TMO (TMO),
    .CW  (CW)
  ) u_tmo (
    .clock  (clock),
    .resetn (resetn),
    .clr    (state == ST_IDLE),
    .en     (state == ST_BUSY),
    .tc     (tmo_tc)
  );

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      state         <= ST_IDLE;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      cpu_rdata     <= '0;
      err_align     <= 1'b0;
      err_tmo       <= 1'b0;
    end else begin
      // Clear first; any error raised below in the same cycle overrides it.
      if (err_clr) begin
        err_align <= 1'b0;
        err_tmo   <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (req) begin
            if (is_word_aligned(cpu_addr[1:0])) begin
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= cpu_wr;
              bus.bus_addr  <= {cpu_addr[AW-1:2], 2'b00};
              bus.bus_wdata <= cpu_wdata;
              state         <= ST_BUSY;
            end else begin
              // No bus cycle: a misaligned read returns zero, a write is dropped.
              err_align <= 1'b1;
              if (!cpu_wr) cpu_rdata <= '0;
              state <= ST_DONE;
            end
          end
        end

        ST_BUSY: begin
          // Ack is tested before the terminal count so a late ack still wins.
          if (bus.bus_ack) begin
            if (!bus.bus_we) cpu_rdata <= bus.bus_rdata;
            bus.bus_req <= 1'b0;
            bus.bus_we  <= 1'b0;
            state       <= ST_DONE;
          end else if (tmo_tc) begin
            if (!bus.bus_we) cpu_rdata <= '0;
            err_tmo     <= 1'b1;
            bus.bus_req <= 1'b0;
            bus.bus_we  <= 1'b0;
            state       <= ST_DONE;
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mc_mem_bus_ctrl
// Transaction-driven bench. Each access is described by (rd, wr, addr, data,
// ack delay); the bench derives the expected per-cycle outputs from those
// rules and a negedge process compares the DUT against them every cycle.
// Directed accesses pin the expectations with literal values, then a
// randomized run mixes reads/writes, misalignment, timeouts and stray acks.
// ---------------------------------------------------------------------------
module tb_mc_mem_bus_ctrl;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;
  localparam int CW  = 5;

  logic          clock = 1'b0;
  logic          resetn = 1'b1;
  logic          cpu_rd = 1'b0;
  logic          cpu_wr = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          err_clr = 1'b0;
  logic          err_align;
  logic          err_tmo;

  mc_mem_bus_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  mc_mem_bus_ctrl #(.AW(AW), .DW(DW), .TMO(TMO), .CW(CW)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .err_clr   (err_clr),
    .err_align (err_align),
    .err_tmo   (err_tmo),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle.
  logic          e_stall = 1'b0;
  logic          e_req = 1'b0;
  logic          e_we = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0;
  logic [DW-1:0] e_rdata = '0;
  logic          e_align = 1'b0;
  logic          e_tmo = 1'b0;
  bit            clr_q = 1'b0;
  bit            chk_en = 1'b0;

  // Observed run lengths, used by the literal checks.
  int   stall_cnt = 0;
  int   last_stall = 0;
  int   req_cnt = 0;
  int   last_req = 0;
  logic seen_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
      chk("bus_req", 32'(bus.bus_req), 32'(e_req));
      if (e_req) begin
        chk("bus_we", 32'(bus.bus_we), 32'(e_we));
        chk("bus_addr", bus.bus_addr, e_addr);
        chk("bus_wdata", bus.bus_wdata, e_wdata);
      end
      chk("cpu_rdata", cpu_rdata, e_rdata);
      chk("err_align", 32'(err_align), 32'(e_align));
      chk("err_tmo", 32'(err_tmo), 32'(e_tmo));
    end
    if (cpu_stall) stall_cnt++;
    else if (stall_cnt != 0) begin last_stall = stall_cnt; stall_cnt = 0; end
    if (bus.bus_req) begin req_cnt++; seen_we = bus.bus_we; end
    else if (req_cnt != 0) begin last_req = req_cnt; req_cnt = 0; end
  end

  // Advance one cycle; a clear driven in the previous cycle now takes effect.
  task automatic step();
    @(posedge clock);
    #1;
    if (clr_q) begin e_align = 1'b0; e_tmo = 1'b0; end
    clr_q = 1'b0;
  endtask

  task automatic drive_clr(input bit v);
    err_clr = v;
    clr_q   = v;
  endtask

  // clr_mode: 0 none, 1 clear in the first cycle, 2 random clears.
  task automatic idle(input int n, input int clr_mode);
    for (int i = 0; i < n; i++) begin
      step();
      cpu_rd = 1'b0; cpu_wr = 1'b0;
      cpu_addr = $urandom; cpu_wdata = $urandom;
      bus.bus_ack = 1'($urandom_range(0, 1));
      bus.bus_rdata = $urandom;
      drive_clr(clr_mode == 1 ? (i == 0) : (clr_mode == 2 ? ($urandom_range(0, 3) == 0) : 1'b0));
      e_stall = 1'b0; e_req = 1'b0;
    end
  endtask

  // One access. ack_k = BUSY cycle (1-based) carrying the ack; 0 or >TMO = none.
  // Returns just after the edge that enters the release cycle.
  task automatic run_txn(input bit rd, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int ack_k,
                         input logic [DW-1:0] rdv, input bit clr_at_set);
    bit aligned, acked;
    int busy_len;
    aligned  = (addr[1:0] == 2'b00);
    acked    = aligned && (ack_k >= 1) && (ack_k <= TMO);
    busy_len = !aligned ? 0 : (acked ? ack_k : TMO);

    step();
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd;
    bus.bus_ack = 1'($urandom_range(0, 1));
    bus.bus_rdata = $urandom;
    drive_clr((busy_len == 0) && clr_at_set);
    e_stall = 1'b1; e_req = 1'b0;

    for (int t = 1; t <= busy_len; t++) begin
      step();
      bus.bus_ack = (t == ack_k);
      bus.bus_rdata = (t == ack_k) ? rdv : DW'($urandom);
      drive_clr((t == busy_len) && clr_at_set);
      e_stall = 1'b1; e_req = 1'b1;
      e_we = wr; e_addr = addr; e_wdata = wd;
    end

    // Release cycle: request still held by the CPU but ignored.
    step();
    bus.bus_ack = 1'($urandom_range(0, 1));
    bus.bus_rdata = $urandom;
    drive_clr(1'b0);
    e_stall = 1'b0; e_req = 1'b0;
    if (!aligned) begin
      e_align = 1'b1;
      if (!wr) e_rdata = '0;
    end else if (acked) begin
      if (!wr) e_rdata = rdv;
    end else begin
      e_tmo = 1'b1;
      if (!wr) e_rdata = '0;
    end
  endtask

  task automatic async_reset();
    resetn = 1'b1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    bus.bus_ack = 1'b0;
    drive_clr(1'b0);
    e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0;
    e_align = 1'b0; e_tmo = 1'b0; e_rdata = '0;
    #1;
    chk("async_bus_req", 32'(bus.bus_req), 32'd0);
    chk("async_stall", 32'(cpu_stall), 32'd0);
    #1 resetn = 1'b0;
  endtask

  initial begin
    bit            rd, wr, cl;
    int            sel, k;
    logic [AW-1:0] a;

    bus.bus_ack = 1'b0;
    bus.bus_rdata = '0;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b0;
    chk_en = 1'b1;
    #4;
    chk("rst_bus_req", 32'(bus.bus_req), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_errs", 32'({err_align, err_tmo}), 32'd0);

    // Read, ack two cycles after bus_req rises.
    run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 2, 32'hCAFE_F00D, 1'b0);
    #5;
    chk("rd_stall_len", last_stall, 3);
    chk("rd_req_len", last_req, 2);
    chk("rd_rdata", cpu_rdata, 32'hCAFE_F00D);
    chk("rd_errs", 32'({err_align, err_tmo}), 32'd0);
    idle(1, 0);

    // Write, immediate ack.
    run_txn(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1, 32'h0, 1'b0);
    #5;
    chk("wr_stall_len", last_stall, 2);
    chk("wr_we", 32'(seen_we), 32'd1);
    chk("wr_rdata_held", cpu_rdata, 32'hCAFE_F00D);
    idle(1, 0);

    // Misaligned read: no bus cycle, zero data, sticky flag, then clear.
    run_txn(1'b1, 1'b0, 32'h0000_0013, 32'h0, 1, 32'hFFFF_FFFF, 1'b0);
    #5;
    chk("mis_stall_len", last_stall, 1);
    chk("mis_align", 32'(err_align), 32'd1);
    chk("mis_rdata", cpu_rdata, 32'd0);
    idle(1, 1);
    idle(1, 0);
    #5;
    chk("mis_clr", 32'(err_align), 32'd0);

    // Read with no ack: timeout after TMO bus cycles; stray acks afterwards.
    run_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 32'h0, 1'b0);
    #5;
    chk("tmo_req_len", last_req, TMO);
    chk("tmo_flag", 32'(err_tmo), 32'd1);
    idle(3, 0);
    #5;
    chk("tmo_stray", cpu_rdata, 32'd0);
    idle(1, 1);

    // Ack in the terminal cycle wins over the timeout.
    run_txn(1'b1, 1'b0, 32'h0000_0044, 32'h0, TMO, 32'hA5A5_0001, 1'b0);
    #5;
    chk("tc_ack_tmo", 32'(err_tmo), 32'd0);
    chk("tc_ack_rdata", cpu_rdata, 32'hA5A5_0001);
    idle(1, 0);

    // Read and write together: write wins.
    run_txn(1'b1, 1'b1, 32'h0000_0048, 32'h0BAD_BEEF, 3, 32'h5555_5555, 1'b0);
    #5;
    chk("both_we", 32'(seen_we), 32'd1);
    chk("both_rdata", cpu_rdata, 32'hA5A5_0001);
    idle(1, 0);

    // Reset in the middle of a bus cycle, then a late ack.
    step();
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0000_0080;
    bus.bus_ack = 1'b0;
    e_stall = 1'b1; e_req = 1'b0;
    for (int t = 0; t < 3; t++) begin
      step();
      e_stall = 1'b1; e_req = 1'b1; e_we = 1'b0;
      e_addr = 32'h0000_0080; e_wdata = cpu_wdata;
    end
    step();
    async_reset();
    step();
    bus.bus_ack = 1'b1;
    bus.bus_rdata = 32'hDEAD_BEEF;
    step();
    bus.bus_ack = 1'b0;
    #4;
    chk("rst_late_ack", cpu_rdata, 32'd0);
    run_txn(1'b1, 1'b0, 32'h0000_0084, 32'h0, 1, 32'h1111_2222, 1'b0);
    idle(1, 0);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 2));
      rd  = (sel != 1);
      wr  = (sel != 0);
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      k = int'($urandom_range(0, TMO + 2));
      if ($urandom_range(0, 1) == 1) k = int'($urandom_range(1, 4));
      cl = 1'($urandom_range(0, 1));
      run_txn(rd, wr, a, $urandom, k, $urandom, cl);
      idle(int'($urandom_range(0, 3)), 2);
    end

    idle(2, 0);
    @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
